// File: rtl/ctrl_pulse_pkg.sv
// Shared definitions for the pulse-width counter-control transmitter:
// command codes, pulse widths and the serialiser state encoding.
package ctrl_pulse_pkg;

   localparam logic [1:0] CMD_RESET = 2'd0;
   localparam logic [1:0] CMD_DOWN  = 2'd1;
   localparam logic [1:0] CMD_UP    = 2'd2;
   localparam logic [1:0] CMD_RSVD  = 2'd3;

   localparam logic [1:0] PW_RESET  = 2'd1;
   localparam logic [1:0] PW_DOWN   = 2'd2;
   localparam logic [1:0] PW_UP     = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PULSE,
      ST_GAP
   } state_t;

   // Number of ctrl-high cycles used to encode a command.
   function automatic logic [1:0] pulse_width(input logic [1:0] code);
      logic [1:0] w;
      case (code)
         CMD_DOWN: w = PW_DOWN;
         CMD_UP:   w = PW_UP;
         default:  w = PW_RESET;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/ctrl_cmd_fifo.sv
// Small synchronous FIFO holding {cmd, step} entries awaiting serialisation.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module ctrl_cmd_fifo #(
   parameter int DW    = 6,
   parameter int DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   input  logic          pop,
   output logic [DW-1:0] dout,
   output logic          full,
   output logic          empty
);

   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Storage write.
   // NOTE: the data array is deliberately left out of reset; the pointers alone
   // define which entries are valid, and an unreset array maps onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Pointer update; push is refused when full, pop when empty.
   // NOTE: sequential state is assigned with non-blocking <= so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/ctrl_pulse_tx.sv
// Transmitter for the single-wire pulse-width counter-control protocol.
// Buffers RESET/DOWN/UP commands, emits each as a 1/2/3-cycle high pulse on
// ctrl followed by a low guard gap, and mirrors the remote counter value.
module ctrl_pulse_tx
   import ctrl_pulse_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int GAP   = 2,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd,
   input  logic [WIDTH-1:0] step,
   output logic             ctrl,
   output logic             busy,
   output logic [WIDTH-1:0] mirror,
   output logic             err
);

   localparam int DW = 2 + WIDTH;
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             pop;
   logic [DW-1:0]    fifo_dout;
   logic [1:0]       head_cmd;
   logic [WIDTH-1:0] head_step;

   state_t           state_q, state_d;
   logic             ctrl_q, ctrl_d;
   logic [1:0]       len_q, len_d;
   logic [GW-1:0]    gcnt_q, gcnt_d;
   logic [1:0]       cur_cmd_q, cur_cmd_d;
   logic [WIDTH-1:0] cur_step_q, cur_step_d;
   logic [WIDTH-1:0] mirror_q, mirror_d;
   logic             err_q;

   // Reserved codes are acknowledged but never enter the queue.
   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && cmd_ready && (cmd != CMD_RSVD);
   assign head_cmd  = fifo_dout[DW-1:WIDTH];
   assign head_step = fifo_dout[WIDTH-1:0];

   ctrl_cmd_fifo #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   ({cmd, step}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Next-state, pulse/gap counting and mirror arithmetic.
   // NOTE: every output of this block gets a default before the case so no
   // path leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      ctrl_d     = ctrl_q;
      len_d      = len_q;
      gcnt_d     = gcnt_q;
      cur_cmd_d  = cur_cmd_q;
      cur_step_d = cur_step_q;
      mirror_d   = mirror_q;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               ctrl_d     = 1'b1;
               cur_cmd_d  = head_cmd;
               cur_step_d = head_step;
               len_d      = pulse_width(head_cmd) - 2'd1;
               state_d    = ST_PULSE;
            end else begin
               ctrl_d = 1'b0;
            end
         end
         ST_PULSE: begin
            if (len_q != 2'd0) begin
               len_d = len_q - 2'd1;
            end else begin
               ctrl_d  = 1'b0;
               gcnt_d  = GW'(GAP - 1);
               state_d = ST_GAP;
            end
         end
         ST_GAP: begin
            if (gcnt_q != '0) begin
               gcnt_d = gcnt_q - GW'(1);
            end else begin
               case (cur_cmd_q)
                  CMD_RESET: mirror_d = '0;
                  CMD_UP:    mirror_d = mirror_q + cur_step_q;
                  CMD_DOWN:  mirror_d = mirror_q - cur_step_q;
                  default:   mirror_d = mirror_q;
               endcase
               state_d = ST_IDLE;
            end
         end
         default: begin
            ctrl_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM, line driver, counters and mirror registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ctrl_q     <= 1'b0;
         len_q      <= '0;
         gcnt_q     <= '0;
         cur_cmd_q  <= CMD_RESET;
         cur_step_q <= '0;
         mirror_q   <= '0;
      end else begin
         state_q    <= state_d;
         ctrl_q     <= ctrl_d;
         len_q      <= len_d;
         gcnt_q     <= gcnt_d;
         cur_cmd_q  <= cur_cmd_d;
         cur_step_q <= cur_step_d;
         mirror_q   <= mirror_d;
      end
   end

   // Sticky reserved-command flag; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q <= 1'b0;
      end else if (cmd_valid && cmd_ready && (cmd == CMD_RSVD)) begin
         err_q <= 1'b1;
      end
   end

   assign ctrl   = ctrl_q;
   assign busy   = !fifo_empty || (state_q != ST_IDLE);
   assign mirror = mirror_q;
   assign err    = err_q;

endmodule

// File: tb/tb_ctrl_pulse_tx.sv
// Directed bench for ctrl_pulse_tx: a background monitor measures pulse
// widths, low gaps and the mirror at each gap exit; scenario tasks compare
// those against hand-computed values.
module tb_ctrl_pulse_tx;
   import ctrl_pulse_pkg::*;

   localparam int WIDTH = 4;
   localparam int GAP   = 2;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             cmd_valid = 1'b0;
   logic             cmd_ready;
   logic [1:0]       cmd = 2'd0;
   logic [WIDTH-1:0] step = '0;
   logic             ctrl;
   logic             busy;
   logic [WIDTH-1:0] mirror;
   logic             err;

   int n_checks = 0;
   int n_pass   = 0;

   int q_width[$];
   int q_gap[$];
   int q_mirror[$];
   int hi_run = 0;
   int lo_run = 0;
   bit seen_pulse = 1'b0;

   always #5 clk = ~clk;

   ctrl_pulse_tx #(
      .WIDTH (WIDTH),
      .GAP   (GAP),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd       (cmd),
      .step      (step),
      .ctrl      (ctrl),
      .busy      (busy),
      .mirror    (mirror),
      .err       (err)
   );

   // Line monitor: sampled 1 time unit after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            hi_run = 0;
            lo_run = 0;
            seen_pulse = 1'b0;
         end else if (ctrl) begin
            if (hi_run == 0 && seen_pulse) q_gap.push_back(lo_run);
            hi_run++;
            lo_run = 0;
         end else begin
            if (hi_run != 0) begin
               q_width.push_back(hi_run);
               seen_pulse = 1'b1;
            end
            hi_run = 0;
            lo_run++;
            // Mirror is updated GAP edges after the falling edge.
            if (seen_pulse && lo_run == GAP + 1) q_mirror.push_back(int'(mirror));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      q_width.delete();
      q_gap.delete();
      q_mirror.delete();
      seen_pulse = 1'b0;
   endtask

   // Offer one command; returns 1 time unit after the accepting edge.
   task automatic send(input logic [1:0] c, input logic [WIDTH-1:0] s);
      int waited = 0;
      cmd = c;
      step = s;
      cmd_valid = 1'b1;
      while (!cmd_ready && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!cmd_ready) begin
         n_checks++;
         $display("FAIL send_timeout: cmd_ready=%0b required 1", cmd_ready);
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (busy) begin
         n_checks++;
         $display("FAIL idle_timeout: busy=%0b required 0", busy);
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (ctrl !== 1'b0) $display("FAIL reset_ctrl: got %0b want 0", ctrl); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else n_pass++;
      n_checks++; if (mirror !== '0) $display("FAIL reset_mirror: got %0d want 0", mirror); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else n_pass++;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %0b want 1", cmd_ready); else n_pass++;
   endtask

   task automatic test_single();
      clear_mon();
      send(CMD_UP, 4'd3);
      wait_idle();
      n_checks++; if (mirror !== 4'd3) $display("FAIL single_up_mirror: got %0d want 3", mirror); else n_pass++;
      send(CMD_RESET, 4'd3);
      // After acceptance edge N: FSM still IDLE-popping, line low.
      n_checks++; if (ctrl !== 1'b0) $display("FAIL single_latency_low: got %0b want 0", ctrl); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (ctrl !== 1'b1) $display("FAIL single_rise: got %0b want 1", ctrl); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (ctrl !== 1'b0) $display("FAIL single_width1: got %0b want 0", ctrl); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy_gap: got %0b want 1", busy); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_fall: got %0b want 0", busy); else n_pass++;
      n_checks++; if (mirror !== 4'd0) $display("FAIL single_reset_mirror: got %0d want 0", mirror); else n_pass++;
      repeat (3) begin @(posedge clk); #1; end
      n_checks++; if (ctrl !== 1'b0) $display("FAIL single_stays_low: got %0b want 0", ctrl); else n_pass++;
   endtask

   task automatic test_sequence();
      logic [1:0] cmds [6] = '{CMD_RESET, CMD_UP, CMD_UP, CMD_DOWN, CMD_UP, CMD_RESET};
      int exp_w [6] = '{1, 3, 3, 2, 3, 1};
      int exp_m [6] = '{0, 3, 6, 3, 6, 0};
      clear_mon();
      for (int i = 0; i < 6; i++) send(cmds[i], 4'd3);
      step = 4'hF;  // live input changes must not affect queued commands
      wait_idle();
      n_checks++; if (q_width.size() != 6) $display("FAIL seq_count: got %0d pulses want 6", q_width.size()); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (i >= q_width.size() || q_width[i] != exp_w[i])
            $display("FAIL seq_width[%0d]: got %0d want %0d", i, (i < q_width.size()) ? q_width[i] : -1, exp_w[i]);
         else n_pass++;
         n_checks++;
         if (i >= q_mirror.size() || q_mirror[i] != exp_m[i])
            $display("FAIL seq_mirror[%0d]: got %0d want %0d", i, (i < q_mirror.size()) ? q_mirror[i] : -1, exp_m[i]);
         else n_pass++;
      end
      n_checks++; if (q_gap.size() != 5) $display("FAIL seq_gap_count: got %0d want 5", q_gap.size()); else n_pass++;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (i >= q_gap.size() || q_gap[i] != GAP + 1)
            $display("FAIL seq_gap[%0d]: got %0d want %0d", i, (i < q_gap.size()) ? q_gap[i] : -1, GAP + 1);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      int exp_m [4] = '{5, 10, 15, 4};
      clear_mon();
      for (int i = 0; i < 4; i++) send(CMD_UP, 4'd5);
      wait_idle();
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= q_mirror.size() || q_mirror[i] != exp_m[i])
            $display("FAIL wrap_mirror[%0d]: got %0d want %0d", i, (i < q_mirror.size()) ? q_mirror[i] : -1, exp_m[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int exp_m [6] = '{7, 14, 5, 12, 3, 10};
      int accepted = 0;
      int first_stall = -1;
      int cyc = 0;
      send(CMD_RESET, 4'd0);
      wait_idle();
      clear_mon();
      cmd = CMD_UP;
      step = 4'd7;
      cmd_valid = 1'b1;
      while (accepted < 6 && cyc < 500) begin
         if (cmd_ready) accepted++;
         else if (first_stall < 0) first_stall = accepted;
         @(posedge clk); #1;
         cyc++;
      end
      cmd_valid = 1'b0;
      n_checks++; if (accepted != 6) $display("FAIL b2b_accepted: got %0d want 6", accepted); else n_pass++;
      // One popped into the FSM plus four resident before ready drops.
      n_checks++; if (first_stall != 5) $display("FAIL b2b_first_stall: got %0d want 5", first_stall); else n_pass++;
      wait_idle();
      n_checks++; if (q_width.size() != 6) $display("FAIL b2b_count: got %0d want 6", q_width.size()); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (i >= q_mirror.size() || q_mirror[i] != exp_m[i] || q_width[i] != 3)
            $display("FAIL b2b_pulse[%0d]: mirror %0d width %0d want mirror %0d width 3", i,
                     (i < q_mirror.size()) ? q_mirror[i] : -1, (i < q_width.size()) ? q_width[i] : -1, exp_m[i]);
         else n_pass++;
      end
      n_checks++; if (mirror !== 4'd10) $display("FAIL b2b_final_mirror: got %0d want 10", mirror); else n_pass++;
   endtask

   task automatic test_reserved();
      bit saw_high = 1'b0;
      send(CMD_RSVD, 4'd5);
      n_checks++; if (err !== 1'b1) $display("FAIL rsvd_err: got %0b want 1", err); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rsvd_busy: got %0b want 0", busy); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         if (ctrl) saw_high = 1'b1;
         @(posedge clk); #1;
      end
      n_checks++; if (saw_high) $display("FAIL rsvd_ctrl: got a pulse want none"); else n_pass++;
      n_checks++; if (err !== 1'b1) $display("FAIL rsvd_err_sticky: got %0b want 1", err); else n_pass++;
      // Mirror left at 10 by the back-to-back scenario.
      n_checks++; if (mirror !== 4'd10) $display("FAIL rsvd_mirror: got %0d want 10", mirror); else n_pass++;
   endtask

   task automatic test_mid_reset();
      send(CMD_UP, 4'd3);
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++; if (ctrl !== 1'b1) $display("FAIL midrst_pulse2: got %0b want 1", ctrl); else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++; if (ctrl !== 1'b0) $display("FAIL midrst_ctrl: got %0b want 0", ctrl); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %0b want 0", busy); else n_pass++;
      n_checks++; if (mirror !== '0) $display("FAIL midrst_mirror: got %0d want 0", mirror); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL midrst_err: got %0b want 0", err); else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      n_checks++; if (busy !== 1'b0) $display("FAIL midrst_fifo_empty: got busy %0b want 0", busy); else n_pass++;
      clear_mon();
      send(CMD_UP, 4'd3);
      n_checks++; if (ctrl !== 1'b0) $display("FAIL midrst_again_low: got %0b want 0", ctrl); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (ctrl !== 1'b1) $display("FAIL midrst_again_rise: got %0b want 1", ctrl); else n_pass++;
      wait_idle();
      n_checks++;
      if (q_width.size() != 1 || q_width[0] != 3)
         $display("FAIL midrst_again_width: got %0d pulses first %0d want 1 pulse width 3",
                  q_width.size(), (q_width.size() > 0) ? q_width[0] : -1);
      else n_pass++;
      n_checks++; if (mirror !== 4'd3) $display("FAIL midrst_again_mirror: got %0d want 3", mirror); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_sequence();
      test_wrap();
      test_back_to_back();
      test_reserved();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
